// File: rtl/isa_pkg.sv
// ISA constants shared by the decode/issue stage: field positions, opcodes,
// funct codes, ALU control codes and the decoded-control bundle.
package isa_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_REG_AW = 3;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RS_MSB  = 11;
  localparam int unsigned RS_LSB  = 9;
  localparam int unsigned RT_MSB  = 8;
  localparam int unsigned RT_LSB  = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned FN_MSB  = 2;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned IMM_MSB = 5;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 6;

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SLTI  = 4'b0101;

  // R-type funct codes
  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_ctrl_e;

  typedef struct packed {
    alu_ctrl_e  alu_ctrl;
    logic       use_imm;    // operand B comes from sign-extended imm6
    logic       uses_rt;    // rt is a real source (hazard check)
    logic [2:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/operand_fwd.sv
// Four-way priority operand select: EX > MEM > WB > register file,
// with register r0 always reading as zero.
module operand_fwd
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  // Youngest matching producer wins
  always_comb begin
    data = rf_data;
    if (src == '0)                      data = '0;
    else if (ex_en && ex_rd == src)     data = ex_data;
    else if (mem_en && mem_rd == src)   data = mem_data;
    else if (wb_en && wb_rd == src)     data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage feeding the ALU: decodes, forwards operands, stalls
// one cycle on load-use, and registers the issued instruction for execute.
module id_ex_stage
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic [REG_AW-1:0] rf_rs_addr,
  output logic [REG_AW-1:0] rf_rt_addr,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [2:0]        out_alu_ctrl,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic [DATA_W-1:0] out_pc,
  output logic              illegal_instr
);

  logic [3:0]        opcode;
  logic [2:0]        funct;
  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rt_idx;
  logic [REG_AW-1:0] rd_idx;
  logic [IMM_W-1:0]  imm6;
  logic [DATA_W-1:0] imm_ext;
  dec_t              dec;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              ex_fwd_en;
  logic              hazard;

  assign opcode  = in_instr[OPC_MSB:OPC_LSB];
  assign rs_idx  = in_instr[RS_MSB:RS_LSB];
  assign rt_idx  = in_instr[RT_MSB:RT_LSB];
  assign rd_idx  = in_instr[RD_MSB:RD_LSB];
  assign funct   = in_instr[FN_MSB:FN_LSB];
  assign imm6    = in_instr[IMM_MSB:IMM_LSB];
  assign imm_ext = {{(DATA_W-IMM_W){imm6[IMM_W-1]}}, imm6};

  assign rf_rs_addr = rs_idx;
  assign rf_rt_addr = rt_idx;

  // Opcode/funct decode into ALU code and control bundle
  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        dec.uses_rt   = 1'b1;
        dec.rd        = rd_idx;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_ctrl = ALU_ADD;
          FN_SUB:  dec.alu_ctrl = ALU_SUB;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          default: dec.illegal  = 1'b1;
        endcase
      end
      OP_LW: begin
        dec.use_imm   = 1'b1;
        dec.rd        = rt_idx;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_SW: begin
        dec.use_imm   = 1'b1;
        dec.uses_rt   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_ctrl  = ALU_SUB;
        dec.uses_rt   = 1'b1;
        dec.branch    = 1'b1;
      end
      OP_ADDI: begin
        dec.use_imm   = 1'b1;
        dec.rd        = rt_idx;
        dec.reg_write = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_ctrl  = ALU_SLT;
        dec.use_imm   = 1'b1;
        dec.rd        = rt_idx;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  // A load in EX cannot forward: its data only exists from MEM onward
  assign ex_fwd_en = out_valid & out_reg_write & ~out_mem_read;

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src      (rs_idx),
    .rf_data  (rf_rs_data),
    .ex_en    (ex_fwd_en),
    .ex_rd    (out_rd),
    .ex_data  (ex_alu_result),
    .mem_en   (exm_wr_en),
    .mem_rd   (exm_rd),
    .mem_data (exm_data),
    .wb_en    (wb_wr_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .data     (rs_val)
  );

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src      (rt_idx),
    .rf_data  (rf_rt_data),
    .ex_en    (ex_fwd_en),
    .ex_rd    (out_rd),
    .ex_data  (ex_alu_result),
    .mem_en   (exm_wr_en),
    .mem_rd   (exm_rd),
    .mem_data (exm_data),
    .wb_en    (wb_wr_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .data     (rt_val)
  );

  // Load-use: the load in EX targets a register this instruction reads
  assign hazard = out_valid & out_mem_read & (out_rd != '0) &
                  ((out_rd == rs_idx) | (dec.uses_rt & (out_rd == rt_idx)));

  assign in_ready = flush | (ex_ready & ~hazard);

  // Issue register: flush > hold > bubble on hazard > load > idle bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_alu_ctrl   <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_branch     <= 1'b0;
      out_pc         <= '0;
      illegal_instr  <= 1'b0;
    end else begin
      illegal_instr <= 1'b0;
      if (flush || (ex_ready && (hazard || !in_valid || dec.illegal))) begin
        out_valid     <= 1'b0;
        out_reg_write <= 1'b0;
        out_mem_read  <= 1'b0;
        out_mem_write <= 1'b0;
        out_branch    <= 1'b0;
        // An illegal opcode is still consumed; it just issues as a bubble
        if (!flush && !hazard && in_valid) illegal_instr <= 1'b1;
      end else if (ex_ready) begin
        out_valid      <= 1'b1;
        out_alu_ctrl   <= dec.alu_ctrl;
        out_rs         <= rs_val;
        out_rt         <= dec.use_imm ? imm_ext : rt_val;
        out_store_data <= rt_val;
        out_rd         <= dec.rd;
        out_reg_write  <= dec.reg_write;
        out_mem_read   <= dec.mem_read;
        out_mem_write  <= dec.mem_write;
        out_branch     <= dec.branch;
        out_pc         <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed test of the decode/issue stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic [2:0]  rf_rs_addr;
  logic [2:0]  rf_rt_addr;
  logic [15:0] rf_rs_data;
  logic [15:0] rf_rt_data;
  logic [15:0] ex_alu_result;
  logic        exm_wr_en;
  logic [2:0]  exm_rd;
  logic [15:0] exm_data;
  logic        wb_wr_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_ready;
  logic        flush;
  logic        out_valid;
  logic [2:0]  out_alu_ctrl;
  logic [15:0] out_rs;
  logic [15:0] out_rt;
  logic [15:0] out_store_data;
  logic [2:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic [15:0] out_pc;
  logic        illegal_instr;

  logic [15:0] regs [8];
  int unsigned checks = 0;
  int unsigned errors = 0;

  assign rf_rs_data = regs[rf_rs_addr];
  assign rf_rt_data = regs[rf_rt_addr];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .rf_rs_addr     (rf_rs_addr),
    .rf_rt_addr     (rf_rt_addr),
    .rf_rs_data     (rf_rs_data),
    .rf_rt_data     (rf_rt_data),
    .ex_alu_result  (ex_alu_result),
    .exm_wr_en      (exm_wr_en),
    .exm_rd         (exm_rd),
    .exm_data       (exm_data),
    .wb_wr_en       (wb_wr_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .ex_ready       (ex_ready),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_alu_ctrl   (out_alu_ctrl),
    .out_rs         (out_rs),
    .out_rt         (out_rt),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_branch     (out_branch),
    .out_pc         (out_pc),
    .illegal_instr  (illegal_instr)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] r_type(input logic [2:0] fn, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [2:0] rd);
    return {4'b0000, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] i_type(input logic [3:0] op, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic offer(input logic [15:0] instr, input logic [15:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    regs[0] = 16'h7777; regs[1] = 16'h0005; regs[2] = 16'h0003; regs[3] = 16'h0000;
    regs[4] = 16'h0040; regs[5] = 16'h0000; regs[6] = 16'h0000; regs[7] = 16'h0000;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    ex_alu_result = '0; exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1; flush = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset in the middle of a load
    offer(i_type(4'b0001, 3'd1, 3'd4, 6'd2), 16'h0010);
    step();
    check_eq("pre_rst_valid", out_valid, 1);
    check_eq("pre_rst_memrd", out_mem_read, 1);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_memrd", out_mem_read, 0);
    check_eq("rst_rs", out_rs, 16'h0000);
    check_eq("rst_pc", out_pc, 16'h0000);
    check_eq("rst_illegal", illegal_instr, 0);
    reset = 1'b0;

    // add r3,r1,r2 from the register file
    offer(r_type(3'b000, 3'd1, 3'd2, 3'd3), 16'h0020);
    #1;
    check_eq("add_rs_addr", rf_rs_addr, 1);
    check_eq("add_rt_addr", rf_rt_addr, 2);
    check_eq("add_ready", in_ready, 1);
    step();
    check_eq("add_valid", out_valid, 1);
    check_eq("add_ctrl", out_alu_ctrl, 3'b000);
    check_eq("add_rs", out_rs, 16'h0005);
    check_eq("add_rt", out_rt, 16'h0003);
    check_eq("add_rd", out_rd, 3);
    check_eq("add_rw", out_reg_write, 1);
    check_eq("add_pc", out_pc, 16'h0020);

    // addi r1,r0,-1: r0 reads zero despite the regfile returning 0x7777
    offer(i_type(4'b0100, 3'd0, 3'd1, 6'h3F), 16'h0022);
    step();
    check_eq("addi_rs_r0", out_rs, 16'h0000);
    check_eq("addi_rt_imm", out_rt, 16'hFFFF);
    check_eq("addi_rd", out_rd, 1);

    // or r2,r1,r1: EX forward beats matching MEM and WB
    ex_alu_result = 16'hFFFF;
    exm_wr_en = 1'b1; exm_rd = 3'd1; exm_data = 16'h1111;
    wb_wr_en  = 1'b1; wb_rd  = 3'd1; wb_data  = 16'h2222;
    offer(r_type(3'b011, 3'd1, 3'd1, 3'd2), 16'h0024);
    step();
    check_eq("fwd_ex_rs", out_rs, 16'hFFFF);
    check_eq("fwd_ex_rt", out_rt, 16'hFFFF);
    check_eq("or_ctrl", out_alu_ctrl, 3'b011);

    // EX now holds r2, so MEM wins for r1
    ex_alu_result = 16'h5555;
    offer(r_type(3'b000, 3'd1, 3'd1, 3'd6), 16'h0026);
    step();
    check_eq("fwd_mem_rs", out_rs, 16'h1111);
    check_eq("fwd_mem_rt", out_rt, 16'h1111);

    // Only WB matches
    exm_wr_en = 1'b0;
    offer(r_type(3'b000, 3'd1, 3'd1, 3'd7), 16'h0028);
    step();
    check_eq("fwd_wb_rs", out_rs, 16'h2222);
    wb_wr_en = 1'b0;

    // lw r4,2(r1) then sub r5,r4,r2: one-cycle stall, then MEM forward
    offer(i_type(4'b0001, 3'd1, 3'd4, 6'd2), 16'h0030);
    step();
    check_eq("lw_rs", out_rs, 16'h0005);
    check_eq("lw_rt", out_rt, 16'h0002);
    check_eq("lw_memrd", out_mem_read, 1);
    check_eq("lw_rd", out_rd, 4);
    offer(r_type(3'b001, 3'd4, 3'd2, 3'd5), 16'h0032);
    #1;
    check_eq("lu_ready0", in_ready, 0);
    step();
    check_eq("lu_bubble", out_valid, 0);
    check_eq("lu_bubble_rw", out_reg_write, 0);
    exm_wr_en = 1'b1; exm_rd = 3'd4; exm_data = 16'hABCD;
    #1;
    check_eq("lu_ready1", in_ready, 1);
    step();
    check_eq("sub_valid", out_valid, 1);
    check_eq("sub_rs_mem", out_rs, 16'hABCD);
    check_eq("sub_rt", out_rt, 16'h0003);
    check_eq("sub_ctrl", out_alu_ctrl, 3'b001);
    check_eq("sub_pc", out_pc, 16'h0032);
    exm_wr_en = 1'b0;

    // lw r4 then addi r4,r2,1: rt is the destination, not a source; no stall
    offer(i_type(4'b0001, 3'd1, 3'd4, 6'd0), 16'h0040);
    step();
    offer(i_type(4'b0100, 3'd2, 3'd4, 6'd1), 16'h0042);
    #1;
    check_eq("noluse_ready", in_ready, 1);
    step();
    check_eq("noluse_valid", out_valid, 1);
    check_eq("noluse_rs", out_rs, 16'h0003);

    // Execute back-pressure: hold for three cycles
    ex_ready = 1'b0;
    offer(r_type(3'b000, 3'd1, 3'd2, 3'd3), 16'h0050);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hold_ready", in_ready, 0);
      step();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_rd", out_rd, 4);
      check_eq("hold_rt", out_rt, 16'h0001);
      check_eq("hold_pc", out_pc, 16'h0042);
    end
    flush = 1'b1;
    #1;
    check_eq("flush_ready", in_ready, 1);
    step();
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_rw", out_reg_write, 0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Illegal opcode then slti r1,r2,0x3F
    offer(16'hF000, 16'h0060);
    step();
    check_eq("ill_pulse", illegal_instr, 1);
    check_eq("ill_valid", out_valid, 0);
    offer(i_type(4'b0101, 3'd2, 3'd1, 6'h3F), 16'h0062);
    step();
    check_eq("ill_clear", illegal_instr, 0);
    check_eq("slti_valid", out_valid, 1);
    check_eq("slti_ctrl", out_alu_ctrl, 3'b100);
    check_eq("slti_rt", out_rt, 16'hFFFF);
    check_eq("slti_rs", out_rs, 16'h0003);

    // Unknown R-type funct is illegal too
    offer(r_type(3'b101, 3'd1, 3'd2, 3'd3), 16'h0064);
    step();
    check_eq("ill_fn_pulse", illegal_instr, 1);
    check_eq("ill_fn_valid", out_valid, 0);

    // Flush suppresses the illegal pulse
    flush = 1'b1;
    offer(16'hF000, 16'h0066);
    step();
    check_eq("ill_flush", illegal_instr, 0);
    flush = 1'b0;

    // sw r2,4(r1)
    offer(i_type(4'b0010, 3'd1, 3'd2, 6'd4), 16'h0070);
    step();
    check_eq("sw_memwr", out_mem_write, 1);
    check_eq("sw_rw", out_reg_write, 0);
    check_eq("sw_sdata", out_store_data, 16'h0003);
    check_eq("sw_rt_imm", out_rt, 16'h0004);
    check_eq("sw_rs", out_rs, 16'h0005);

    // addi r0,r1,5: write to r0 suppressed
    offer(i_type(4'b0100, 3'd1, 3'd0, 6'd5), 16'h0072);
    step();
    check_eq("r0_valid", out_valid, 1);
    check_eq("r0_rw", out_reg_write, 0);

    // beq r1,r2
    offer(i_type(4'b0011, 3'd1, 3'd2, 6'd0), 16'h0074);
    step();
    check_eq("beq_ctrl", out_alu_ctrl, 3'b001);
    check_eq("beq_rt", out_rt, 16'h0003);
    check_eq("beq_branch", out_branch, 1);

    // Idle: valid and controls drop
    in_valid = 1'b0;
    step();
    check_eq("idle_valid", out_valid, 0);
    check_eq("idle_branch", out_branch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
